// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its pedestrian request front end.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        LOCKOUT = 2'd2
    } ped_state_e;

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_PENDING = PENDING;
    localparam logic [1:0] ST_LOCKOUT = LOCKOUT;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_LOCKOUT_CYCLES  = 8;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for the pedestrian button.
module button_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_clean
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [DW-1:0] dcnt;

    // Any cycle where s2 agrees with the clean level restarts the count, so glitches never accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            btn_clean <= 1'b0;
            dcnt      <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            if (s2 == btn_clean) begin
                dcnt <= '0;
            end else if (dcnt == DMAX) begin
                btn_clean <= s2;
                dcnt      <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ped_request_ctrl.sv
// Pedestrian request controller: debounced press edge latched as a request until served, then a lockout.
module ped_request_ctrl
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       serve,
    output logic       press,
    output logic       wait_lamp,
    output logic       btn_clean,
    output logic [1:0] state
);

    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LW-1:0] LMAX = LW'(LOCKOUT_CYCLES - 1);

    logic          btn_clean_q;
    logic          press_event;
    logic [1:0]    state_nxt;
    logic [LW-1:0] lcnt;
    logic [LW-1:0] lcnt_nxt;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_clean(btn_clean)
    );

    assign press_event = btn_clean & ~btn_clean_q;

    always_comb begin
        state_nxt = state;
        lcnt_nxt  = lcnt;
        case (state)
            ST_IDLE: begin
                if (press_event) state_nxt = ST_PENDING;
            end
            ST_PENDING: begin
                if (serve) begin
                    state_nxt = ST_LOCKOUT;
                    lcnt_nxt  = LMAX;
                end
            end
            ST_LOCKOUT: begin
                // Exit is decided on lcnt alone, so an edge arriving on the exit cycle is dropped.
                if (lcnt == '0) state_nxt = ST_IDLE;
                else            lcnt_nxt  = lcnt - 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            lcnt        <= '0;
            btn_clean_q <= 1'b0;
            press       <= 1'b0;
            wait_lamp   <= 1'b0;
        end else begin
            state       <= state_nxt;
            lcnt        <= lcnt_nxt;
            btn_clean_q <= btn_clean;
            press       <= (state_nxt == ST_PENDING);
            wait_lamp   <= (state_nxt == ST_PENDING);
        end
    end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// Scoreboard bench for ped_request_ctrl: stimulus schedules expected outputs per edge, a monitor checks them.
module tb_ped_request_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic       serve;
    logic       press;
    logic       wait_lamp;
    logic       btn_clean;
    logic [1:0] state;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        logic [4:0] val;
        logic [4:0] mask;
        string      name;
    } exp_t;

    exp_t sb[$];

    localparam logic [4:0] M_ALL = 5'b11111;
    localparam logic [4:0] M_P   = 5'b10000;
    localparam logic [4:0] M_W   = 5'b01000;
    localparam logic [4:0] M_C   = 5'b00100;
    localparam logic [4:0] M_S   = 5'b00011;

    ped_request_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .serve    (serve),
        .press    (press),
        .wait_lamp(wait_lamp),
        .btn_clean(btn_clean),
        .state    (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: after edge N (sampled on the following falling edge) check everything scheduled for N.
    always @(negedge clk) begin
        logic [4:0] obs;
        exp_t       e;
        obs = {press, wait_lamp, btn_clean, state};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.cyc != cyc || ((obs ^ e.val) & e.mask) != 5'b0) begin
                bad++;
                $display("FAIL %s @edge %0d: got {press,wait,clean,state}=%b, want %b (mask %b)",
                         e.name, e.cyc, obs, e.val, e.mask);
            end
        end
    end

    task automatic chk(input int e, input logic p, input logic w, input logic c,
                       input logic [1:0] s, input logic [4:0] m, input string nm);
        exp_t x;
        int   i;
        x.cyc  = e;
        x.val  = {p, w, c, s};
        x.mask = m;
        x.name = nm;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= e) i++;
        sb.insert(i, x);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    initial begin
        int k, n, k2, n2, k3, n3;
        rst     = 1'b1;
        btn_raw = 1'b1;
        serve   = 1'b0;

        // Reset with button held; the clean level then rises 5 edges after release and makes a request.
        for (int e = 1; e <= 3; e++) chk(e, 0, 0, 0, 2'd0, M_ALL, "reset_state");
        chk(8,  0, 0, 0, 2'd0, M_C,   "clean_before_debounce");
        chk(9,  0, 0, 1, 2'd0, M_ALL, "clean_after_reset");
        chk(10, 1, 1, 1, 2'd1, M_ALL, "press_after_reset");
        repeat (3) step();
        rst = 1'b0;

        // Reset in PENDING discards the request.
        wait_until(10);
        rst     = 1'b1;
        btn_raw = 1'b0;
        chk(11, 0, 0, 0, 2'd0, M_ALL, "reset_mid_pending");
        for (int e = 12; e <= 24; e++) chk(e, 0, 0, 0, 2'd0, M_P | M_S, "no_retain_after_reset");
        step();
        rst = 1'b0;

        // Bounce: 2-cycle pulses never survive the debouncer.
        wait_until(24);
        for (int e = 25; e <= 50; e++) chk(e, 0, 0, 0, 2'd0, M_P | M_C | M_S, "bounce_rejected");
        for (int i = 0; i < 12; i++) begin
            btn_raw = ((i / 2) % 2) == 0;
            step();
        end
        btn_raw = 1'b0;

        // Clean press.
        wait_until(50);
        btn_raw = 1'b1;
        k = cyc + 1;
        chk(k + 4,  0, 0, 0, 2'd0, M_C,   "clean_press_early");
        chk(k + 5,  0, 0, 1, 2'd0, M_ALL, "clean_press_debounced");
        chk(k + 6,  1, 1, 1, 2'd1, M_ALL, "press_rise");
        chk(k + 12, 1, 1, 0, 2'd1, M_P | M_W | M_S, "press_hold_no_serve");
        wait_until(k + 8);
        btn_raw = 1'b0;

        // Serve, then a short press during lockout is dropped.
        wait_until(70);
        serve = 1'b1;
        n = cyc + 1;
        chk(n - 1, 1, 0, 0, 2'd1, M_P | M_S, "pre_serve");
        chk(n,     0, 0, 0, 2'd2, M_ALL, "serve_to_lockout");
        chk(n + 6, 0, 0, 1, 2'd2, M_C | M_S, "lockout_press_clean");
        chk(n + 7, 0, 0, 1, 2'd2, M_P | M_S, "lockout_last_cycle");
        chk(n + 8, 0, 0, 0, 2'd0, M_P | M_S, "idle_after_lockout");
        chk(n + 9, 0, 0, 0, 2'd0, M_P | M_S, "lockout_press_dropped");
        chk(n + 12, 0, 0, 0, 2'd0, M_ALL, "lockout_press_settled");
        step();
        serve   = 1'b0;
        btn_raw = 1'b1;
        wait_until(n + 5);
        btn_raw = 1'b0;

        // Fresh press in IDLE with a simultaneous serve: serve is ignored.
        wait_until(n + 15);
        btn_raw = 1'b1;
        k2 = cyc + 1;
        chk(k2 + 6, 1, 1, 1, 2'd1, M_ALL, "press_with_serve_idle");
        chk(k2 + 8, 1, 1, 1, 2'd1, M_P | M_S, "serve_ignored_in_idle");
        wait_until(k2 + 5);
        serve = 1'b1;
        step();
        serve = 1'b0;

        // Button held through serve and the whole lockout: no new request.
        wait_until(k2 + 10);
        serve = 1'b1;
        n2 = cyc + 1;
        chk(n2,      0, 0, 1, 2'd2, M_ALL, "held_serve");
        chk(n2 + 7,  0, 0, 1, 2'd2, M_S, "held_lockout_last");
        chk(n2 + 8,  0, 0, 1, 2'd0, M_ALL, "held_idle");
        chk(n2 + 10, 0, 0, 1, 2'd0, M_P | M_S, "held_no_retrigger");
        chk(n2 + 20, 0, 0, 1, 2'd0, M_ALL, "held_no_retrigger_late");
        step();
        serve = 1'b0;
        wait_until(n2 + 20);
        btn_raw = 1'b0;
        wait_until(n2 + 30);
        btn_raw = 1'b1;
        k3 = cyc + 1;
        chk(k3 + 5, 0, 0, 1, 2'd0, M_ALL, "repress_debounced");
        chk(k3 + 6, 1, 1, 1, 2'd1, M_ALL, "repress_pending");
        wait_until(k3 + 8);
        btn_raw = 1'b0;

        // Clean edge on the lockout exit cycle is dropped.
        wait_until(k3 + 20);
        serve = 1'b1;
        n3 = cyc + 1;
        chk(n3 + 7,  0, 0, 1, 2'd2, M_P | M_C | M_S, "exit_edge_clean");
        chk(n3 + 8,  0, 0, 1, 2'd0, M_P | M_S, "exit_edge_idle");
        chk(n3 + 9,  0, 0, 1, 2'd0, M_ALL, "exit_edge_dropped");
        chk(n3 + 12, 0, 0, 1, 2'd0, M_ALL, "exit_edge_dropped_late");
        step();
        serve = 1'b0;
        step();
        btn_raw = 1'b1;

        wait_until(n3 + 15);
        btn_raw = 1'b0;
        repeat (3) step();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
